// File: rtl/ntt_butterfly.sv
// Pipelined Kyber NTT butterfly (CT forward / GS inverse), q = 3329.
// Four-edge latency, one op per cycle, global stall on output backpressure.
module ntt_butterfly #(
  parameter int Q     = 3329,
  parameter int TW_AW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [11:0]      in_a,
  input  logic [11:0]      in_b,
  input  logic [TW_AW-1:0] in_tw_idx,
  output logic [TW_AW-1:0] tw_addr,
  input  logic [11:0]      tw_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_a,
  output logic [11:0]      out_b,
  output logic             pipe_empty
);

  localparam logic [12:0] QV = 13'(Q);
  // floor(2^24 / 3329); quotient estimate is at most one low
  localparam logic [12:0] BM = 13'd5039;

  logic             accept;
  logic [TW_AW-1:0] tw_q;

  logic             v1, m1;
  logic [11:0]      a1, b1;
  logic             v2, m2;
  logic [11:0]      a2;
  logic [23:0]      p2;
  logic             v3, m3;
  logic [11:0]      a3, r3;

  assign in_ready   = !(out_valid && !out_ready);
  assign accept     = in_valid && in_ready;
  assign tw_addr    = (accept && rst_n) ? in_tw_idx : tw_q;
  assign pipe_empty = !(v1 || v2 || v3 || out_valid);

  // S2 combinational: modular sum/difference and twiddle product
  logic [12:0] sum1, dif1;
  logic [11:0] s1, d1, mul_in, carry1;
  logic [23:0] prod1;

  assign sum1   = {1'b0, a1} + {1'b0, b1};
  assign dif1   = {1'b0, a1} - {1'b0, b1};
  assign s1     = 12'((sum1 >= QV) ? sum1 - QV : sum1);
  assign d1     = 12'((a1 < b1) ? dif1 + QV : dif1);
  assign mul_in = m1 ? d1 : b1;
  assign carry1 = m1 ? s1 : a1;
  assign prod1  = 24'(mul_in) * 24'(tw_data);

  // S3 combinational: Barrett reduction with one correction
  logic [12:0] qest, rraw, red2;
  logic [23:0] qq;

  assign qest = 13'((37'(p2) * 37'(BM)) >> 24);
  assign qq   = 24'(qest) * 24'(QV);
  assign rraw = 13'(p2 - qq);
  assign red2 = (rraw >= QV) ? rraw - QV : rraw;

  // Output combinational: CT add/sub of a and r
  logic [12:0] csum, cdif;
  logic [11:0] ct_a, ct_b, nxt_a, nxt_b;

  assign csum  = {1'b0, a3} + {1'b0, r3};
  assign cdif  = {1'b0, a3} - {1'b0, r3};
  assign ct_a  = 12'((csum >= QV) ? csum - QV : csum);
  assign ct_b  = 12'((a3 < r3) ? cdif + QV : cdif);
  assign nxt_a = m3 ? a3 : ct_a;
  assign nxt_b = m3 ? r3 : ct_b;

  // S1 capture and last accepted twiddle index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      m1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      tw_q <= '0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        m1   <= in_mode;
        a1   <= in_a;
        b1   <= in_b;
        tw_q <= in_tw_idx;
      end
    end
  end

  // S2 register: carried coefficient and 24-bit product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      m2 <= 1'b0;
      a2 <= '0;
      p2 <= '0;
    end else if (in_ready) begin
      v2 <= v1;
      if (v1) begin
        m2 <= m1;
        a2 <= carry1;
        p2 <= prod1;
      end
    end
  end

  // S3 register: reduced product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0;
      m3 <= 1'b0;
      a3 <= '0;
      r3 <= '0;
    end else if (in_ready) begin
      v3 <= v2;
      if (v2) begin
        m3 <= m2;
        a3 <= a2;
        r3 <= 12'(red2);
      end
    end
  end

  // Output register: holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (in_ready) begin
      out_valid <= v3;
      if (v3) begin
        out_a <= nxt_a;
        out_b <= nxt_b;
      end
    end
  end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly against a plain modular model.
// Twiddle ROM is modelled here as a synchronous lookup table.
module tb_ntt_butterfly;
  localparam int Q  = 3329;
  localparam int AW = 8;
  localparam int N  = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [11:0]   in_a = '0;
  logic [11:0]   in_b = '0;
  logic [AW-1:0] in_tw_idx = '0;
  logic [AW-1:0] tw_addr;
  logic [11:0]   tw_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [11:0]   out_a;
  logic [11:0]   out_b;
  logic          pipe_empty;

  int errors = 0;
  int checks = 0;

  logic [11:0] rom [256];
  logic [23:0] exp_q [$];

  ntt_butterfly #(.Q(3329), .TW_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b),
    .in_tw_idx(in_tw_idx), .tw_addr(tw_addr), .tw_data(tw_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .pipe_empty(pipe_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tw_data <= rom[tw_addr];

  function automatic logic [23:0] golden(bit mode, int a, int b, int w);
    int r, oa, ob;
    if (!mode) begin
      r  = (b * w) % Q;
      oa = (a + r) % Q;
      ob = (a - r + Q) % Q;
    end else begin
      oa = (a + b) % Q;
      ob = (((a - b + Q) % Q) * w) % Q;
    end
    return {12'(oa), 12'(ob)};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || pipe_empty !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags got v=%b e=%b r=%b want 0 1 1",
               out_valid, pipe_empty, in_ready);
    end
    checks++;
    if (out_a !== 12'd0 || out_b !== 12'd0 || tw_addr !== 8'd0) begin
      errors++;
      $display("FAIL reset_data got a=%0d b=%0d t=%0d want 0 0 0",
               out_a, out_b, tw_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [36:0] vec [6];
    vec[0] = {1'b0, 12'd1,    12'd1,    12'd1, 12'd0};
    vec[1] = {1'b0, 12'd3328, 12'd3328, 12'd1, 12'd0};
    vec[2] = {1'b0, 12'd0,    12'd2,    12'd2, 12'd0};
    vec[3] = {1'b1, 12'd5,    12'd3,    12'd0, 12'd0};
    vec[4] = {1'b1, 12'd3,    12'd5,    12'd0, 12'd0};
    vec[5] = {1'b0, 12'd100,  12'd200,  12'd7, 12'd0};
    for (int i = 0; i < 6; i++) begin
      logic [23:0] exp;
      logic [36:0] v;
      int lat;
      v = vec[i];
      @(negedge clk);
      in_valid  = 1'b1;
      in_mode   = v[36];
      in_a      = v[35:24];
      in_b      = v[23:12];
      in_tw_idx = AW'(v[11:0]);
      out_ready = 1'b1;
      exp = golden(v[36], int'(v[35:24]), int'(v[23:12]),
                   int'(rom[v[7:0]]));
      #1;
      checks++;
      if (tw_addr !== AW'(v[11:0])) begin
        errors++;
        $display("FAIL dir%0d_tw_addr got=%0d want=%0d", i, tw_addr, v[7:0]);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (pipe_empty !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_pipe_empty got=%b want=0", i, pipe_empty);
      end
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL dir%0d_latency got=%0d want=4", i, lat);
      end
      checks++;
      if ({out_a, out_b} !== exp) begin
        errors++;
        $display("FAIL dir%0d_result got a=%0d b=%0d want a=%0d b=%0d",
                 i, out_a, out_b, exp[23:12], exp[11:0]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (pipe_empty !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dir_drain got e=%b v=%b want 1 0", pipe_empty, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0]   ba [6];
    logic [11:0]   bb [6];
    bit            bm [6];
    logic [AW-1:0] bi [6];
    logic [11:0]   ha, hb;
    logic [AW-1:0] ht;
    int sent, got, c, first_pop, last_pop;
    bit seen;
    for (int i = 0; i < 6; i++) begin
      ba[i] = 12'($urandom_range(0, Q - 1));
      bb[i] = 12'($urandom_range(0, Q - 1));
      bm[i] = 1'($urandom_range(0, 1));
      bi[i] = AW'($urandom_range(0, 255));
    end
    sent = 0;
    got = 0;
    seen = 0;
    out_ready = 1'b0;
    for (c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_a = ba[sent]; in_b = bb[sent];
        in_mode = bm[sent]; in_tw_idx = bi[sent];
      end
      #1;
      if (out_valid) seen = 1;
      else if (in_valid && in_ready) sent++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_first_valid got=timeout want=out_valid");
    end
    checks++;
    if (in_ready !== 1'b0 || sent !== 4) begin
      errors++;
      $display("FAIL bp_stall got ready=%b sent=%0d want 0 4", in_ready, sent);
    end
    checks++;
    if (tw_addr !== bi[3]) begin
      errors++;
      $display("FAIL bp_tw_addr got=%0d want=%0d", tw_addr, bi[3]);
    end
    ha = out_a;
    hb = out_b;
    ht = tw_addr;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_a !== ha || out_b !== hb ||
          tw_addr !== ht || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got v=%b a=%0d b=%0d t=%0d want 1 %0d %0d %0d",
                 out_valid, out_a, out_b, tw_addr, ha, hb, ht);
      end
    end
    first_pop = -1;
    last_pop = -1;
    for (c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_a = ba[sent]; in_b = bb[sent];
        in_mode = bm[sent]; in_tw_idx = bi[sent];
      end
      #1;
      if (out_valid && out_ready) begin
        logic [23:0] exp;
        exp = golden(bm[got], int'(ba[got]), int'(bb[got]), int'(rom[bi[got]]));
        checks++;
        if ({out_a, out_b} !== exp) begin
          errors++;
          $display("FAIL bp_result%0d got a=%0d b=%0d want a=%0d b=%0d",
                   got, out_a, out_b, exp[23:12], exp[11:0]);
        end
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 6 || (last_pop - first_pop) !== 5) begin
      errors++;
      $display("FAIL bp_drain got n=%0d span=%0d want n=6 span=5",
               got, last_pop - first_pop);
    end
  endtask

  task automatic test_reset_midflight();
    logic [23:0] exp;
    int lat;
    bit stray;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mode = 1'b0;
      in_a = 12'(10 + i);
      in_b = 12'(20 + i);
      in_tw_idx = AW'(3 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pipe_empty !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_a !== 12'd0 || out_b !== 12'd0 || tw_addr !== 8'd0) begin
      errors++;
      $display("FAIL midrst_clear got e=%b v=%b r=%b a=%0d b=%0d t=%0d want 1 0 1 0 0 0",
               pipe_empty, out_valid, in_ready, out_a, out_b, tw_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || !pipe_empty) stray = 1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL midrst_stray got=out_valid want=idle");
    end
    in_valid = 1'b1;
    in_mode = 1'b1;
    in_a = 12'd1000;
    in_b = 12'd2500;
    in_tw_idx = 8'd9;
    exp = golden(1'b1, 1000, 2500, int'(rom[9]));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== 4 || {out_a, out_b} !== exp) begin
      errors++;
      $display("FAIL midrst_new got lat=%0d a=%0d b=%0d want 4 %0d %0d",
               lat, out_a, out_b, exp[23:12], exp[11:0]);
    end
  endtask

  task automatic test_soak();
    int sent, got, cyc;
    bit prev_stall;
    logic [11:0] pa, pb;
    sent = 0;
    got = 0;
    cyc = 0;
    prev_stall = 0;
    pa = '0;
    pb = '0;
    exp_q.delete();
    while (got < N && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid = (sent < N) && ($urandom_range(0, 99) < 70);
      if (in_valid) begin
        in_a = 12'($urandom_range(0, Q - 1));
        in_b = 12'($urandom_range(0, Q - 1));
        in_mode = 1'($urandom_range(0, 1));
        in_tw_idx = AW'($urandom_range(0, 255));
      end
      out_ready = (sent >= N) || ($urandom_range(0, 99) < 70);
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL soak_in_ready got=%b cyc=%0d", in_ready, cyc);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_a !== pa || out_b !== pb) begin
          errors++;
          $display("FAIL soak_hold got v=%b a=%0d b=%0d want 1 %0d %0d",
                   out_valid, out_a, out_b, pa, pb);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL soak_extra got a=%0d b=%0d want=none", out_a, out_b);
        end else begin
          logic [23:0] exp;
          exp = exp_q.pop_front();
          if ({out_a, out_b} !== exp) begin
            errors++;
            $display("FAIL soak_result%0d got a=%0d b=%0d want a=%0d b=%0d",
                     got, out_a, out_b, exp[23:12], exp[11:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(golden(in_mode, int'(in_a), int'(in_b),
                               int'(rom[in_tw_idx])));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      pa = out_a;
      pb = out_b;
    end
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (got !== N || exp_q.size() !== 0 || pipe_empty !== 1'b1) begin
      errors++;
      $display("FAIL soak_count got n=%0d left=%0d e=%b want n=%0d left=0 e=1",
               got, exp_q.size(), pipe_empty, N);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 12'($urandom_range(0, Q - 1));
    rom[0] = 12'd1;
    rom[1] = 12'd3328;
    rom[2] = 12'd1600;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
